// File: rtl/vga_pkg.sv
// Shared VGA timing types: per-axis timing record, video flag bundle and the
// two built-in mode defaults (mode 0 = 640x480, mode 1 = 800x600).
package vga_pkg;

  localparam int TW = 16;

  typedef struct packed {
    logic [TW-1:0] act;
    logic [TW-1:0] fp;
    logic [TW-1:0] syn;
    logic [TW-1:0] bp;
    logic          pol;
  } axis_tim_t;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } vid_flags_t;

  localparam axis_tim_t H_MODE0 = '{act: 16'd640, fp: 16'd16, syn: 16'd96,  bp: 16'd48, pol: 1'b0};
  localparam axis_tim_t V_MODE0 = '{act: 16'd480, fp: 16'd10, syn: 16'd2,   bp: 16'd33, pol: 1'b0};
  localparam axis_tim_t H_MODE1 = '{act: 16'd800, fp: 16'd40, syn: 16'd128, bp: 16'd88, pol: 1'b1};
  localparam axis_tim_t V_MODE1 = '{act: 16'd600, fp: 16'd1,  syn: 16'd4,   bp: 16'd23, pol: 1'b1};

  function automatic axis_tim_t mk_tim(input int unsigned a, input int unsigned f,
                                       input int unsigned s, input int unsigned b,
                                       input logic p);
    axis_tim_t t;
    t.act = TW'(a);
    t.fp  = TW'(f);
    t.syn = TW'(s);
    t.bp  = TW'(b);
    t.pol = p;
    return t;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One display axis: position counter with wrap at the axis total, plus raw
// active decode and polarity-corrected sync level for the given timing record.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int CW = 11
) (
  input  logic          VGA_clk,
  input  logic          rst_n,
  input  logic          step,
  input  axis_tim_t     tim,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          act_raw,
  output logic          sync_lvl
);

  logic [TW-1:0] cnt_ext;
  logic [TW-1:0] sync_beg;
  logic [TW-1:0] sync_end;
  logic [TW-1:0] tot;
  logic          sync_raw;

  assign cnt_ext  = TW'(count);
  assign sync_beg = tim.act + tim.fp;
  assign sync_end = sync_beg + tim.syn;
  assign tot      = sync_end + tim.bp;

  assign wrap     = (cnt_ext == tot - TW'(1));
  assign act_raw  = (cnt_ext < tim.act);
  assign sync_raw = (cnt_ext >= sync_beg) && (cnt_ext < sync_end);
  // Asserted sync drives the record's polarity level.
  assign sync_lvl = sync_raw ? tim.pol : ~tim.pol;

  always_ff @(posedge VGA_clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Two-mode VGA timing generator: H/V axis counters, frame-aligned mode switch,
// and a pix_en-advanced delay line carrying already polarity-corrected flags.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CW       = 11,
  parameter int H_ACT0   = int'(H_MODE0.act),
  parameter int H_FP0    = int'(H_MODE0.fp),
  parameter int H_SYN0   = int'(H_MODE0.syn),
  parameter int H_BP0    = int'(H_MODE0.bp),
  parameter int V_ACT0   = int'(V_MODE0.act),
  parameter int V_FP0    = int'(V_MODE0.fp),
  parameter int V_SYN0   = int'(V_MODE0.syn),
  parameter int V_BP0    = int'(V_MODE0.bp),
  parameter int H_ACT1   = int'(H_MODE1.act),
  parameter int H_FP1    = int'(H_MODE1.fp),
  parameter int H_SYN1   = int'(H_MODE1.syn),
  parameter int H_BP1    = int'(H_MODE1.bp),
  parameter int V_ACT1   = int'(V_MODE1.act),
  parameter int V_FP1    = int'(V_MODE1.fp),
  parameter int V_SYN1   = int'(V_MODE1.syn),
  parameter int V_BP1    = int'(V_MODE1.bp),
  parameter bit HS_POL0  = 1'b0,
  parameter bit VS_POL0  = 1'b0,
  parameter bit HS_POL1  = 1'b1,
  parameter bit VS_POL1  = 1'b1,
  parameter int PIPE_DLY = 2
) (
  input  logic          VGA_clk,
  input  logic          rst_n,
  input  logic          pix_en,
  input  logic          mode_sel,
  output logic [CW-1:0] xCount,
  output logic [CW-1:0] yCount,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          blank_n,
  output logic          line_start,
  output logic          frame_start,
  output logic          cur_mode
);

  localparam axis_tim_t H_T0 = mk_tim(H_ACT0, H_FP0, H_SYN0, H_BP0, HS_POL0);
  localparam axis_tim_t V_T0 = mk_tim(V_ACT0, V_FP0, V_SYN0, V_BP0, VS_POL0);
  localparam axis_tim_t H_T1 = mk_tim(H_ACT1, H_FP1, H_SYN1, H_BP1, HS_POL1);
  localparam axis_tim_t V_T1 = mk_tim(V_ACT1, V_FP1, V_SYN1, V_BP1, VS_POL1);

  axis_tim_t  h_tim;
  axis_tim_t  v_tim;
  logic       h_wrap, v_wrap;
  logic       h_act, v_act;
  logic       h_lvl, v_lvl;
  logic       hpol_rst, vpol_rst;
  vid_flags_t raw_f;
  vid_flags_t rst_f;
  vid_flags_t pipe [0:PIPE_DLY];

  assign h_tim    = cur_mode ? H_T1 : H_T0;
  assign v_tim    = cur_mode ? V_T1 : V_T0;
  assign hpol_rst = mode_sel ? HS_POL1 : HS_POL0;
  assign vpol_rst = mode_sel ? VS_POL1 : VS_POL0;

  vga_axis_counter #(.CW(CW)) u_h_axis (
    .VGA_clk  (VGA_clk),
    .rst_n    (rst_n),
    .step     (pix_en),
    .tim      (h_tim),
    .count    (xCount),
    .wrap     (h_wrap),
    .act_raw  (h_act),
    .sync_lvl (h_lvl)
  );

  vga_axis_counter #(.CW(CW)) u_v_axis (
    .VGA_clk  (VGA_clk),
    .rst_n    (rst_n),
    .step     (pix_en & h_wrap),
    .tim      (v_tim),
    .count    (yCount),
    .wrap     (v_wrap),
    .act_raw  (v_act),
    .sync_lvl (v_lvl)
  );

  always_comb begin
    raw_f     = '0;
    raw_f.act = h_act & v_act;
    raw_f.hs  = h_lvl;
    raw_f.vs  = v_lvl;
    rst_f     = '0;
    rst_f.hs  = ~hpol_rst;
    rst_f.vs  = ~vpol_rst;
  end

  // Polarity is folded in before the delay line, so in-flight samples keep
  // the old mode's levels across a mode switch.
  always_ff @(posedge VGA_clk) begin
    if (!rst_n) begin
      cur_mode <= mode_sel;
      for (int i = 0; i <= PIPE_DLY; i++) pipe[i] <= rst_f;
    end else if (pix_en) begin
      if (h_wrap && v_wrap) cur_mode <= mode_sel;
      pipe[0] <= raw_f;
      for (int i = 1; i <= PIPE_DLY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign active      = pipe[PIPE_DLY].act;
  assign blank_n     = pipe[PIPE_DLY].act;
  assign hsync       = pipe[PIPE_DLY].hs;
  assign vsync       = pipe[PIPE_DLY].vs;
  assign line_start  = rst_n & pix_en & (xCount == '0);
  assign frame_start = line_start & (yCount == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-timing instance under random pix_en, mode
// and reset stimulus against a position/history model, plus a default 640x480 instance.
module tb_vga_timing_gen;

  localparam int CW = 11;
  localparam int PD = 3;
  localparam int HA[2] = '{8, 10};
  localparam int HF[2] = '{2, 2};
  localparam int HS[2] = '{3, 4};
  localparam int HB[2] = '{2, 3};
  localparam int VA[2] = '{5, 6};
  localparam int VF[2] = '{1, 1};
  localparam int VS[2] = '{2, 1};
  localparam int VB[2] = '{2, 2};
  localparam bit HP[2] = '{1'b0, 1'b1};
  localparam bit VP[2] = '{1'b0, 1'b1};

  logic VGA_clk = 1'b0;
  always #5 VGA_clk = ~VGA_clk;

  // small-timing instance
  logic rst_n = 1'b0, pix_en = 1'b0, mode_sel = 1'b0;
  logic [CW-1:0] x_a, y_a;
  logic act_a, hs_a, vs_a, bn_a, ls_a, fs_a, cm_a;

  // default-timing instance
  logic rst_b = 1'b0, pe_b = 1'b1, ms_b = 1'b0;
  logic [CW-1:0] x_b, y_b;
  logic act_b, hs_b, vs_b, bn_b, ls_b, fs_b, cm_b;

  vga_timing_gen #(
    .CW(CW),
    .H_ACT0(HA[0]), .H_FP0(HF[0]), .H_SYN0(HS[0]), .H_BP0(HB[0]),
    .V_ACT0(VA[0]), .V_FP0(VF[0]), .V_SYN0(VS[0]), .V_BP0(VB[0]),
    .H_ACT1(HA[1]), .H_FP1(HF[1]), .H_SYN1(HS[1]), .H_BP1(HB[1]),
    .V_ACT1(VA[1]), .V_FP1(VF[1]), .V_SYN1(VS[1]), .V_BP1(VB[1]),
    .HS_POL0(HP[0]), .VS_POL0(VP[0]), .HS_POL1(HP[1]), .VS_POL1(VP[1]),
    .PIPE_DLY(PD)
  ) u_dut_a (
    .VGA_clk(VGA_clk), .rst_n(rst_n), .pix_en(pix_en), .mode_sel(mode_sel),
    .xCount(x_a), .yCount(y_a), .active(act_a), .hsync(hs_a), .vsync(vs_a),
    .blank_n(bn_a), .line_start(ls_a), .frame_start(fs_a), .cur_mode(cm_a)
  );

  vga_timing_gen #(.PIPE_DLY(0)) u_dut_b (
    .VGA_clk(VGA_clk), .rst_n(rst_b), .pix_en(pe_b), .mode_sel(ms_b),
    .xCount(x_b), .yCount(y_b), .active(act_b), .hsync(hs_b), .vsync(vs_b),
    .blank_n(bn_b), .line_start(ls_b), .frame_start(fs_b), .cur_mode(cm_b)
  );

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic act, hs, vs, ls, fs, mode;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp_v, $time);
    end
  endtask

  // ---------------- reference model: position, mode, output history ----------
  int   m_x = 0, m_y = 0, m_mode = 0;
  bit   m_valid = 1'b0;
  logic [2:0] hist[$];

  function automatic logic [2:0] flags_of(input int x, input int y, input int m);
    logic a, h, v;
    a = (x < HA[m]) && (y < VA[m]);
    h = (x >= HA[m] + HF[m] && x < HA[m] + HF[m] + HS[m]) ? HP[m] : !HP[m];
    v = (y >= VA[m] + VF[m] && y < VA[m] + VF[m] + VS[m]) ? VP[m] : !VP[m];
    return {a, h, v};
  endfunction

  task automatic model_edge();
    int ht, vt;
    if (!rst_n) begin
      m_x = 0; m_y = 0; m_mode = int'(mode_sel); m_valid = 1'b1;
      hist.delete();
      repeat (PD + 1) hist.push_back({1'b0, !HP[m_mode], !VP[m_mode]});
    end else if (pix_en && m_valid) begin
      hist.push_back(flags_of(m_x, m_y, m_mode));
      void'(hist.pop_front());
      ht = HA[m_mode] + HF[m_mode] + HS[m_mode] + HB[m_mode];
      vt = VA[m_mode] + VF[m_mode] + VS[m_mode] + VB[m_mode];
      if (m_x == ht - 1) begin
        m_x = 0;
        if (m_y == vt - 1) begin
          m_y = 0;
          m_mode = int'(mode_sel);
        end else m_y++;
      end else m_x++;
    end
  endtask

  task automatic step_a(input logic r, input logic p, input logic m);
    exp_t e;
    @(posedge VGA_clk);
    model_edge();
    #1;
    rst_n = r; pix_en = p; mode_sel = m;
    if (m_valid) begin
      e.x    = CW'(m_x);
      e.y    = CW'(m_y);
      e.act  = hist[0][2];
      e.hs   = hist[0][1];
      e.vs   = hist[0][0];
      e.ls   = r && p && (m_x == 0);
      e.fs   = r && p && (m_x == 0) && (m_y == 0);
      e.mode = m_mode[0];
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_a();
    logic ms;
    ms = 1'b0;
    step_a(1'b0, 1'b0, 1'b0);
    step_a(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 400; i++) step_a(1'b1, (i % 2) == 0, 1'b0);
    ms = 1'b1;
    for (int k = 0; k < 3000 && !(m_y == 3 && m_x == 5); k++) step_a(1'b1, 1'b1, ms);
    step_a(1'b0, 1'b1, ms);
    step_a(1'b1, 1'b1, ms);
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 149) == 0) ms = ~ms;
      step_a($urandom_range(0, 599) != 0, $urandom_range(0, 99) < 75, ms);
    end
  endtask

  always @(negedge VGA_clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("xCount",      x_a,  e.x);
      check("yCount",      y_a,  e.y);
      check("active",      act_a, e.act);
      check("blank_n",     bn_a, e.act);
      check("hsync",       hs_a, e.hs);
      check("vsync",       vs_a, e.vs);
      check("line_start",  ls_a, e.ls);
      check("frame_start", fs_a, e.fs);
      check("cur_mode",    cm_a, e.mode);
    end
  end

  // ---------------- default 640x480 instance, PIPE_DLY=0 ----------------------
  bit b_run = 1'b0;
  int b_cyc = 0, b_last_ls = -1, b_prev_x = -1, b_prev_y = -1;

  task automatic drive_b();
    rst_b = 1'b0;
    repeat (2) @(posedge VGA_clk);
    #1 rst_b = 1'b1;
    b_run = 1'b1;
    repeat (1700) @(posedge VGA_clk);
    b_run = 1'b0;
  endtask

  always @(negedge VGA_clk) begin
    if (b_run) begin
      check("b_hsync", hs_b, !(b_prev_x >= 656 && b_prev_x < 752));
      check("b_active", act_b, (b_prev_x >= 0 && b_prev_x < 640 && b_prev_y >= 0 && b_prev_y < 480));
      if (ls_b) begin
        if (b_last_ls >= 0) check("b_line_period", b_cyc - b_last_ls, 800);
        else check("b_first_frame_start", fs_b, 1'b1);
        b_last_ls = b_cyc;
      end
      b_prev_x = int'(x_b);
      b_prev_y = int'(y_b);
      b_cyc++;
    end
  end

  initial begin
    fork
      drive_a();
      drive_b();
    join
    repeat (2) @(posedge VGA_clk);
    #1 check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
